// File: rtl/uart_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_pkg
// Description : J1 I/O address map and status-word layout for the UART block.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_io_pkg;

    localparam logic [15:0] UART_RX_ADDR   = 16'h4000;
    localparam logic [15:0] UART_TX_ADDR   = 16'h4001;
    localparam logic [15:0] UART_STAT_ADDR = 16'h4002;

    localparam int STAT_NE      = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_TXBUSY  = 3;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [0:0] {
        ING_IDLE = 1'b0,
        ING_HOLD = 1'b1
    } ingest_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Power-of-two synchronous FIFO with combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetq,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                  c_addr_w   = $clog2(DEPTH);
    localparam logic [c_addr_w-1:0] c_ptr_one  = 1;
    localparam logic [c_addr_w:0]   c_cnt_one  = 1;
    localparam logic [c_addr_w:0]   c_full_cnt = DEPTH[c_addr_w:0];

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_pop;
    logic                w_push;

    // A pop frees the slot the same-cycle push needs when the FIFO is full.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_full_cnt);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Drains UART rx bytes into a FIFO and serves them on J1 I/O reads.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_io_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DATA_ADDR = UART_RX_ADDR,
    parameter logic [15:0] STAT_ADDR = UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        uart_valid,
    input  logic [7:0]  uart_data,
    output logic        uart_rd,
    input  logic        tx_busy,
    input  logic        io_rd,
    input  logic [15:0] io_addr,
    output logic [15:0] io_din,
    output logic        rx_ready
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    ingest_state_t      r_state;
    logic               r_uart_rd;
    logic               r_overflow;
    logic               w_ingest;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_stat_rd;
    logic               w_full;
    logic               w_empty;
    logic [7:0]         w_head;
    logic [c_cnt_w-1:0] w_count;
    logic [15:0]        w_din;

    assign w_ingest  = (r_state == ING_IDLE) && uart_valid;
    assign w_pop     = io_rd && (io_addr == DATA_ADDR) && !w_empty;
    assign w_push    = w_ingest && (!w_full || w_pop);
    assign w_drop    = w_ingest && !w_push;
    assign w_stat_rd = io_rd && (io_addr == STAT_ADDR);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (uart_data),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // HOLD gives the UART one cycle to drop valid after the acknowledge.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_state   <= ING_IDLE;
            r_uart_rd <= 1'b0;
        end else begin
            case (r_state)
                ING_IDLE: begin
                    r_uart_rd <= uart_valid;
                    if (uart_valid) r_state <= ING_HOLD;
                end
                default: begin
                    r_uart_rd <= 1'b0;
                    r_state   <= ING_IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk) begin
        if (!resetq)        r_overflow <= 1'b0;
        else if (w_drop)    r_overflow <= 1'b1;
        else if (w_stat_rd) r_overflow <= 1'b0;
    end

    always_comb begin
        w_din = 16'h0000;
        if (io_addr == DATA_ADDR) begin
            if (!w_empty) w_din = {8'h00, w_head};
        end else if (io_addr == STAT_ADDR) begin
            w_din[STAT_NE]               = !w_empty;
            w_din[STAT_FULL]             = w_full;
            w_din[STAT_OVF]              = r_overflow;
            w_din[STAT_TXBUSY]           = tx_busy;
            w_din[STAT_CNT_LSB +: 8]     = 8'(w_count);
        end
    end

    assign io_din   = w_din;
    assign uart_rd  = r_uart_rd;
    assign rx_ready = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed and random checks of uart_rx_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int          DEPTH = 16;
    localparam logic [15:0] DADDR = 16'h4000;
    localparam logic [15:0] SADDR = 16'h4002;

    logic        clk = 1'b0;
    logic        resetq;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        uart_rd;
    logic        tx_busy;
    logic        io_rd;
    logic [15:0] io_addr;
    logic [15:0] io_din;
    logic        rx_ready;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .DATA_ADDR (DADDR),
        .STAT_ADDR (SADDR)
    ) dut (
        .clk        (clk),
        .resetq     (resetq),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_rd    (uart_rd),
        .tx_busy    (tx_busy),
        .io_rd      (io_rd),
        .io_addr    (io_addr),
        .io_din     (io_din),
        .rx_ready   (rx_ready)
    );

    // Reference model: byte queue, sticky overflow, "ingested last cycle" flag.
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_hold;
    bit         m_uart_rd;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_din();
        logic [15:0] s;
        s = 16'h0000;
        if (io_addr == DADDR) begin
            if (q.size() > 0) s = {8'h00, q[0]};
        end else if (io_addr == SADDR) begin
            s[0]    = (q.size() != 0);
            s[1]    = (q.size() == DEPTH);
            s[2]    = m_ovf;
            s[3]    = tx_busy;
            s[15:8] = 8'(q.size());
        end
        return s;
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic rd,
                        input logic [15:0] a, output logic [15:0] din);
        bit ingest;
        bit pop;
        bit full0;
        uart_valid = v;
        uart_data  = d;
        io_rd      = rd;
        io_addr    = a;
        #1;
        din = io_din;
        chk("io_din", io_din, exp_din());
        chk("uart_rd", {15'b0, uart_rd}, {15'b0, m_uart_rd});
        chk("rx_ready", {15'b0, rx_ready}, {15'b0, (q.size() != 0)});
        @(posedge clk);
        if (!resetq) begin
            q.delete();
            m_ovf = 0; m_hold = 0; m_uart_rd = 0;
        end else begin
            ingest = !m_hold && v;
            pop    = rd && (a == DADDR) && (q.size() > 0);
            full0  = (q.size() == DEPTH);
            if (pop) void'(q.pop_front());
            if (ingest && (!full0 || pop)) q.push_back(d);
            if (ingest && full0 && !pop)     m_ovf = 1;
            else if (rd && (a == SADDR))     m_ovf = 0;
            m_uart_rd = ingest;
            m_hold    = ingest;
        end
        @(negedge clk);
    endtask

    // UART presents the byte, then drops valid while the acknowledge is out.
    task automatic send(input logic [7:0] b);
        logic [15:0] dummy;
        step(1'b1, b, 1'b0, 16'h0000, dummy);
        step(1'b0, 8'h00, 1'b0, 16'h0000, dummy);
    endtask

    task automatic rd_data(output logic [15:0] din);
        step(1'b0, 8'h00, 1'b1, DADDR, din);
    endtask

    task automatic rd_stat(output logic [15:0] din);
        step(1'b0, 8'h00, 1'b1, SADDR, din);
    endtask

    initial begin
        logic [15:0] d;
        resetq = 1'b0; uart_valid = 1'b0; uart_data = 8'h00;
        tx_busy = 1'b0; io_rd = 1'b0; io_addr = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(1'b0, 8'h00, 1'b0, SADDR, d);
        resetq = 1'b1;

        rd_stat(d);                          chk("reset_stat", d, 16'h0000);

        send(8'h41);
        rd_stat(d);                          chk("stat_one", d, 16'h0101);
        rd_data(d);                          chk("data_41", d, 16'h0041);
        rd_stat(d);                          chk("stat_empty", d, 16'h0000);

        for (int i = 0; i < 16; i++) send(8'(i));
        rd_stat(d);                          chk("stat_full", d, 16'h1003);
        send(8'hAA);
        rd_stat(d);                          chk("stat_ovf", d, 16'h1007);
        rd_stat(d);                          chk("stat_ovf_clr", d, 16'h1003);
        for (int i = 0; i < 16; i++) begin
            rd_data(d);                      chk("drain_order", d, 16'(i));
        end

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) send(8'(8'h20 + 10 * r + i));
            for (int i = 0; i < 10; i++) begin
                rd_data(d);                  chk("wrap_order", d, 16'(8'h20 + 10 * r + i));
            end
        end
        rd_stat(d);                          chk("wrap_end", d, 16'h0000);

        for (int i = 0; i < 16; i++) send(8'(8'h50 + i));
        step(1'b1, 8'h77, 1'b1, DADDR, d);   chk("full_pushpop_head", d, 16'h0050);
        rd_stat(d);                          chk("full_pushpop_stat", d, 16'h1003);
        for (int i = 1; i < 16; i++) begin
            rd_data(d);                      chk("full_pushpop_order", d, 16'(8'h50 + i));
        end
        rd_data(d);                          chk("full_pushpop_last", d, 16'h0077);

        for (int i = 0; i < 16; i++) send(8'(8'h60 + i));
        step(1'b1, 8'hEE, 1'b1, SADDR, d);   chk("ovf_race_before", d, 16'h1003);
        rd_stat(d);                          chk("ovf_set_wins", d, 16'h1007);
        rd_stat(d);                          chk("ovf_race_clr", d, 16'h1003);

        step(1'b1, 8'h99, 1'b0, 16'h0000, d);
        resetq = 1'b0;
        step(1'b0, 8'h00, 1'b0, 16'h0000, d);
        resetq = 1'b1;
        rd_stat(d);                          chk("midop_reset", d, 16'h0000);

        rd_data(d);                          chk("empty_read", d, 16'h0000);
        rd_stat(d);                          chk("empty_read_stat", d, 16'h0000);
        send(8'h3C);
        rd_data(d);                          chk("after_empty_read", d, 16'h003C);
        tx_busy = 1'b1;
        rd_stat(d);                          chk("tx_busy", d, 16'h0008);
        tx_busy = 1'b0;

        for (int n = 0; n < 600; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0:       a = DADDR;
                1:       a = SADDR;
                2:       a = 16'h4001;
                default: a = 16'($urandom);
            endcase
            tx_busy = 1'($urandom_range(0, 1));
            resetq  = ($urandom_range(0, 149) != 0);
            step(($urandom_range(0, 9) < 6), 8'($urandom),
                 ($urandom_range(0, 9) < 4), a, d);
            resetq = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the byte UART (`buart`) and the J1 I/O bus.
- Drains each byte from the UART as soon as it is valid, so back-to-back serial bytes are not lost while the CPU is busy.
- Queues bytes in a power-of-two FIFO and presents them, plus a status word, on J1 I/O reads.
- Replaces the direct UART-to-CPU rx path and address decode at top level. The TX path is untouched; only `tx_busy` is reported.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..128.
- DATA_ADDR, 16'h4000, I/O address of the RX data register (read pops).
- STAT_ADDR, 16'h4002, I/O address of the status register (read-only; read clears overflow).

Ports:
- clk  in  1  system clock
- resetq  in  1  synchronous active-low reset
- uart_valid  in  1  UART holds a received byte
- uart_data  in  8  received byte from UART
- uart_rd  out  1  one-cycle acknowledge to UART, consumes the held byte
- tx_busy  in  1  UART transmitter busy, reported in status
- io_rd  in  1  J1 I/O read strobe
- io_addr  in  16  J1 I/O address
- io_din  out  16  read data to J1
- rx_ready  out  1  FIFO non-empty (LED or interrupt use)

Behaviour:
- Reset (resetq=0 at a clk edge):
  - rd/wr pointers, count and overflow cleared to 0.
  - uart_rd=0; rx_ready=0; holdoff flag cleared.
  - FIFO storage is not cleared.
- Ingest FSM, two states:
  - IDLE: if uart_valid=1, assert uart_rd for exactly one cycle and go to HOLD.
    - If the FIFO is not full, or a pop occurs in the same cycle, write uart_data at wr_ptr; wr_ptr++ modulo DEPTH.
    - Otherwise drop the byte and set overflow=1 (sticky).
  - HOLD: one cycle, uart_rd=0, no sampling. Covers the UART's one-cycle valid deassert latency. Return to IDLE.
  - Maximum ingest rate is one byte per 2 cycles, far above the serial rate.
- Pop:
  - A pop occurs when io_rd=1, io_addr==DATA_ADDR and count>0; rd_ptr++ at that clk edge.
  - With count==0 the read is a no-op with no pointer change.
- io_din is combinational from the current state:
  - DATA_ADDR: {8'h00, mem[rd_ptr]} when count>0, else 16'h0000.
  - STAT_ADDR: bit0=count!=0, bit1=count==DEPTH, bit2=overflow, bit3=tx_busy, bits7:4=0, bits15:8=count, zero-extended.
  - Any other address: 16'h0000.
- Status read: io_rd=1 with io_addr==STAT_ADDR clears overflow at that edge. If an overflow event occurs in the same cycle, set wins and overflow stays 1.
- Count rules:
  - push only: count+1; pop only: count-1; push and pop together: unchanged.
  - Push and pop in the same cycle when full: accepted, no overflow.
  - Push and pop in the same cycle when empty: the pop is ignored and the push proceeds, so count becomes 1.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- rx_ready = (count!=0), registered state, no extra latency.
- Reset mid-operation: pending HOLD is abandoned and buffered bytes are lost. Any byte still held by the UART is taken on the first IDLE cycle after reset releases.

Decomposition:
- Package uart_io_pkg holds:
  - UART_RX_ADDR=16'h4000, UART_TX_ADDR=16'h4001, UART_STAT_ADDR=16'h4002.
  - Status bit indices STAT_NE=0, STAT_FULL=1, STAT_OVF=2, STAT_TXBUSY=3, STAT_CNT_LSB=8.
- Sub-module sync_fifo (parameter DEPTH, WIDTH) provides storage, pointers, count, full/empty and push/pop.
- uart_rx_fifo keeps only the ingest FSM, overflow flag and io decode/mux.

Test Plan:
- Reset, then read STAT_ADDR -> io_din=16'h0000, rx_ready=0, uart_rd=0.
- uart_valid with byte 8'h41, UART drops valid after ack -> single uart_rd pulse; STAT=16'h0101; DATA read returns 16'h0041; next STAT=16'h0000.
- 16 bytes 8'h00..8'h0F with no CPU reads -> STAT=16'h1003. A 17th byte 8'hAA is acked and dropped -> STAT=16'h1007. Status read clears overflow -> next STAT=16'h1003. Then 16 DATA reads return 0x00..0x0F in order.
- Wrap: push 10, pop 10, push 10, pop 10 -> bytes returned in order, count 0 at end, no overflow.
- FIFO full with DATA read and new byte in the same cycle -> count stays 16, overflow=0, new byte appears last.
- DATA read while empty -> 16'h0000, pointers unchanged. tx_busy=1 -> STAT bit3=1.
